alu_share_arb: RTL

Two-port round-robin arbiter and sequencer that shares the single combinational `alu` between two requesters, for example a branch-compare unit and an address-generation unit. It accepts one operation at a time through a valid/ready handshake and drives the ALU from registered operands. It captures the result and flags, then holds the response until the owning requester accepts it. It sits between the requesters and the `alu_if` of the one ALU instance.

---
 rtl/alu_share_arb.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Latency: accept edge T, ALU sampled at T+1, response valid from T+1 until accepted; backpressure holds RESP.
module alu_share_arb #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [WORD_W-1:0] req_a0,
  input  logic [WORD_W-1:0] req_a1,
  input  logic [WORD_W-1:0] req_b0,
  input  logic [WORD_W-1:0] req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic [2:0]        rsp_flags,
  output logic [OP_W-1:0]   alu_op,
  output logic [WORD_W-1:0] alu_a,
  output logic [WORD_W-1:0] alu_b,
  input  logic [WORD_W-1:0] alu_out,
  input  logic              alu_ovf,
  input  logic              alu_neg,
  input  logic              alu_zero,
  output logic              busy,
  output logic [15:0]       op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              own_q, own_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic [WORD_W-1:0] res_q, res_d;
  logic [2:0]        flg_q, flg_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              gnt;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    own_d     = own_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    flg_d     = flg_q;
    cnt_d     = cnt_q;
    gnt       = 1'b0;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          // On contention the requester not served last wins.
          gnt            = (&req_valid) ? ~last_q : req_valid[1];
          req_ready[gnt] = 1'b1;
          own_d          = gnt;
          op_d           = gnt ? req_op1 : req_op0;
          a_d            = gnt ? req_a1  : req_a0;
          b_d            = gnt ? req_b1  : req_b0;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_out;
        flg_d   = {alu_ovf, alu_neg, alu_zero};
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[own_q] = 1'b1;
        if (rsp_ready[own_q]) begin
          last_d  = own_q;
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      cnt_q   <= cnt_d;
    end
  end

  // ALU inputs come straight from the latched operands so they stay stable through RESP.
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_data  = res_q;
  assign rsp_flags = flg_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = cnt_q;

endmodule
